// File: rtl/mfp_seq.sv
// Memory-to-memory FP multiply sequencer: operand ROM -> external multiplier -> result RAM.
// Optional sticky NaN/Inf/zero product flags are enabled by defining MFP_SEQ_EXC_FLAGS_EN.
module mfp_seq #(
    parameter int DATA_W      = 32,
    parameter int RAM_AW      = 2,
    parameter int ROM_AW      = 3,
    parameter int MUL_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    output logic [ROM_AW-1:0]   rom_addr,
    output logic                rom_oe,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    output logic                mul_rst,
    output logic                mul_en,
    input  logic                mul_done,
    input  logic [DATA_W-1:0]   mul_z,
    input  logic [RAM_AW-1:0]   ram_addr_juiz,
    output logic [DATA_W-1:0]   ram_out_juiz,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef MFP_SEQ_EXC_FLAGS_EN
    ,
    output logic [2:0]          exc_flags
`endif
);
    localparam int N_RES = 2**RAM_AW;
    localparam int CNT_W = $clog2(MUL_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, RD_A, CAP_A, RD_B, CAP_B, MRST, MRUN, WR, DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [RAM_AW-1:0]  i_reg;
    logic               mode_reg;
    logic [DATA_W-1:0]  prod_reg;
    logic [DATA_W-1:0]  mul_a_reg, mul_b_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg, done_reg, err_reg;
    logic [DATA_W-1:0]  ram [N_RES];

    logic [ROM_AW-1:0]  addr_even;
    logic               mul_ok;
    logic               last_idx;
    logic               timeout;

    assign addr_even = ROM_AW'(i_reg) << 1;
    // The first MRUN cycle ignores mul_done so a stale done from the previous product is never taken.
    assign mul_ok    = mul_done && (cnt_reg != '0);
    assign last_idx  = &i_reg;
    assign timeout   = !mul_ok && (cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        rom_oe     = 1'b0;
        rom_addr   = '0;
        mul_rst    = 1'b0;
        mul_en     = 1'b0;
        case (state_reg)
            IDLE:  if (start) state_next = RD_A;
            RD_A: begin
                rom_oe     = 1'b1;
                rom_addr   = mode_reg ? '0 : addr_even;
                state_next = CAP_A;
            end
            CAP_A: begin
                rom_oe     = 1'b1;
                rom_addr   = mode_reg ? ROM_AW'(1) : (addr_even | ROM_AW'(1));
                state_next = CAP_B;
            end
            RD_B: begin
                rom_oe     = 1'b1;
                rom_addr   = ROM_AW'(i_reg) + ROM_AW'(1);
                state_next = CAP_B;
            end
            CAP_B: state_next = MRST;
            MRST: begin
                mul_rst    = 1'b1;
                state_next = MRUN;
            end
            MRUN: begin
                mul_en = 1'b1;
                if (mul_ok)       state_next = WR;
                else if (timeout) state_next = IDLE;
            end
            WR: begin
                if (last_idx)      state_next = DONE;
                else if (mode_reg) state_next = RD_B;
                else               state_next = RD_A;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef MFP_SEQ_EXC_FLAGS_EN
    logic [2:0] exc_reg;
    logic       exp_ones, exp_zero, man_zero;
    assign exp_ones  = &mul_z[30:23];
    assign exp_zero  = ~|mul_z[30:23];
    assign man_zero  = ~|mul_z[22:0];
    assign exc_flags = exc_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            i_reg     <= '0;
            mode_reg  <= 1'b0;
            prod_reg  <= '0;
            mul_a_reg <= '0;
            mul_b_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
`ifdef MFP_SEQ_EXC_FLAGS_EN
            exc_reg   <= 3'b000;
`endif
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    mode_reg <= mode;
                    i_reg    <= '0;
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    busy_reg <= 1'b1;
`ifdef MFP_SEQ_EXC_FLAGS_EN
                    exc_reg  <= 3'b000;
`endif
                end
                CAP_A: mul_a_reg <= rom_data;
                RD_B:  mul_a_reg <= prod_reg;
                CAP_B: mul_b_reg <= rom_data;
                MRST:  cnt_reg   <= '0;
                MRUN: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (timeout) begin
                        err_reg  <= 1'b1;
                        busy_reg <= 1'b0;
                    end
                end
                WR: begin
                    prod_reg <= mul_z;
`ifdef MFP_SEQ_EXC_FLAGS_EN
                    exc_reg  <= exc_reg | {exp_ones & ~man_zero, exp_ones & man_zero, exp_zero & man_zero};
`endif
                    if (last_idx) begin
                        done_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end else begin
                        i_reg <= i_reg + RAM_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Result RAM keeps its contents across reset; a reset during WR suppresses that write.
    always_ff @(posedge clk) begin
        if (!rst && state_reg == WR) ram[i_reg] <= mul_z;
    end

    assign ram_out_juiz = ram[ram_addr_juiz];
    assign mul_a        = mul_a_reg;
    assign mul_b        = mul_b_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_mfp_seq.sv
// Directed bench for mfp_seq: behavioural ROM and table-lookup multiplier, RAM checked via the judge port.
module tb_mfp_seq;
    localparam int K = 3;

    logic        clk = 1'b0;
    logic        rst, start, mode;
    logic [2:0]  rom_addr;
    logic        rom_oe;
    logic [31:0] rom_data;
    logic [31:0] mul_a, mul_b, mul_z;
    logic        mul_rst, mul_en, mul_done;
    logic [1:0]  ram_addr_juiz;
    logic [31:0] ram_out_juiz;
    logic        busy, done, err;
`ifdef MFP_SEQ_EXC_FLAGS_EN
    logic [2:0]  exc_flags;
`endif

    always #5 clk = ~clk;

    mfp_seq #(.DATA_W(32), .RAM_AW(2), .ROM_AW(3), .MUL_TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .rom_addr(rom_addr), .rom_oe(rom_oe), .rom_data(rom_data),
        .mul_a(mul_a), .mul_b(mul_b), .mul_rst(mul_rst), .mul_en(mul_en),
        .mul_done(mul_done), .mul_z(mul_z),
        .ram_addr_juiz(ram_addr_juiz), .ram_out_juiz(ram_out_juiz),
        .busy(busy), .done(done), .err(err)
`ifdef MFP_SEQ_EXC_FLAGS_EN
        , .exc_flags(exc_flags)
`endif
    );

    // Operand ROM with one-cycle read latency
    logic [31:0] rom [8];
    logic [31:0] rom_q;
    always @(posedge clk) if (rom_oe) rom_q <= rom[rom_addr];
    assign rom_data = rom_q;

    // Multiplier: done in the K-th enabled cycle after mul_rst; product from a table of known results
    logic mul_dead;
    int   mcnt;
    always @(posedge clk) begin
        if (mul_rst)     mcnt <= 0;
        else if (mul_en) mcnt <= mcnt + 1;
    end
    assign mul_done = mul_en && !mul_dead && (mcnt == K - 1);

    function automatic logic [31:0] mul_lut(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h40000000_40400000: return 32'h40C00000;
            64'h3FC00000_40000000: return 32'h40400000;
            64'hBF800000_40800000: return 32'hC0800000;
            64'h3F000000_3F000000: return 32'h3E800000;
            64'h40C00000_3F000000: return 32'h40400000;
            64'h40400000_40800000: return 32'h41400000;
            64'h41400000_3F800000: return 32'h41400000;
            64'h7F800000_00000000: return 32'h7FC00000;
            64'h3F800000_3F800000: return 32'h3F800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = mul_lut(a, b);
        if (r == 32'hDEADBEEF) r = mul_lut(b, a);
        return r;
    endfunction
    assign mul_z = mul_model(mul_a, mul_b);

    logic [2:0] addr_log[$];
    logic       log_en;
    always @(negedge clk) if (log_en && rom_oe) addr_log.push_back(rom_addr);

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } ram_vec_t;
    ram_vec_t ram_tab[12];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 32'({busy, done, err, rom_oe, mul_en, mul_rst}), 32'd0);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_mul_a"}, mul_a, 32'd0);
        check({tag, "_mul_b"}, mul_b, 32'd0);
    endtask

    task automatic check_ram(input int p);
        for (int j = 0; j < 4; j++) begin
            ram_addr_juiz = ram_tab[4*p+j].addr;
            #1;
            check($sformatf("ram_p%0d_a%0d", p, j), ram_out_juiz, ram_tab[4*p+j].exp);
        end
    endtask

    task automatic do_start(input logic m);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges after the start edge until done/err; samples the judge port at probe and probe+1
    task automatic wait_run(input int probe, input int ign, output int n,
                            output logic [31:0] s0, output logic [31:0] s1, output logic busy_ok);
        n = 0; s0 = '0; s1 = '0; busy_ok = 1'b1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (n == probe)     s0 = ram_out_juiz;
            if (n == probe + 1) s1 = ram_out_juiz;
            if (done || err) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == ign) begin start = 1'b1; mode = 1'b0; end
            else start = 1'b0;
        end
        start = 1'b0;
    endtask

    int          n, seen;
    logic [31:0] s0, s1;
    logic        bok;

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0; mul_dead = 1'b0; log_en = 1'b0; ram_addr_juiz = '0;
        ram_tab[0]  = '{2'd0, 32'h40C00000}; ram_tab[1]  = '{2'd1, 32'h40400000};
        ram_tab[2]  = '{2'd2, 32'hC0800000}; ram_tab[3]  = '{2'd3, 32'h3E800000};
        ram_tab[4]  = '{2'd0, 32'h40C00000}; ram_tab[5]  = '{2'd1, 32'h40400000};
        ram_tab[6]  = '{2'd2, 32'h41400000}; ram_tab[7]  = '{2'd3, 32'h41400000};
        ram_tab[8]  = '{2'd3, 32'h3E800000}; ram_tab[9]  = '{2'd2, 32'hC0800000};
        ram_tab[10] = '{2'd1, 32'h40400000}; ram_tab[11] = '{2'd0, 32'h40C00000};

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        // Pairwise run, k=3: 4 results of 8 cycles each
        rom = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h40000000,
                32'hBF800000, 32'h40800000, 32'h3F000000, 32'h3F000000};
        do_start(1'b0);
        wait_run(-5, -1, n, s0, s1, bok);
        check("pw_latency", n, 32);
        check("pw_done", 32'(done), 32'd1);
        check("pw_busy_end", 32'(busy), 32'd0);
        check("pw_busy_during", 32'(bok), 32'd1);
        check_ram(0);

        // Running product; a start during the run must be ignored
        rom = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000,
                32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000};
        ram_addr_juiz = 2'd2;
        addr_log.delete();
        log_en = 1'b1;
        do_start(1'b1);
        wait_run(21, 5, n, s0, s1, bok);
        log_en = 1'b0;
        check("rn_latency", n, 29);
        check("rn_done", 32'(done), 32'd1);
        check("rn_wr_old_data", s0, 32'hC0800000);
        check("rn_wr_new_data", s1, 32'h41400000);
        check("rn_addr_count", addr_log.size(), 5);
        for (int k = 0; k < 5 && k < addr_log.size(); k++)
            check($sformatf("rn_rom_addr%0d", k), 32'(addr_log[k]), k);
        check_ram(1);

        // Watchdog: dead multiplier, then a working run clears err
        mul_dead = 1'b1;
        rom = '{32'h40000000, 32'h40400000, 32'h3FC00000, 32'h40000000,
                32'hBF800000, 32'h40800000, 32'h3F000000, 32'h3F000000};
        do_start(1'b0);
        wait_run(-5, -1, n, s0, s1, bok);
        check("wd_latency", n, 68);
        check("wd_err", 32'(err), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_done", 32'(done), 32'd0);
        mul_dead = 1'b0;
        do_start(1'b0);
        check("wd_err_cleared", 32'(err), 32'd0);
        check("wd_busy_restart", 32'(busy), 32'd1);
        wait_run(-5, -1, n, s0, s1, bok);
        check("wd_rerun_latency", n, 32);
        check("wd_rerun_done", 32'(done), 32'd1);
        check("wd_rerun_err", 32'(err), 32'd0);

        // Reset during MRUN of i=2 in running mode
        rom = '{32'h40000000, 32'h40400000, 32'h3F000000, 32'h40800000,
                32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000};
        do_start(1'b1);
        seen = 0;
        for (int c = 0; c < 200 && seen < 3; c++) begin
            @(negedge clk);
            if (mul_rst) seen++;
        end
        check("rs_found_mrst", seen, 3);
        @(negedge clk);
        check("rs_in_mrun", 32'(mul_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("rs_midrun");
        rst = 1'b0;
        check_ram(2);

`ifdef MFP_SEQ_EXC_FLAGS_EN
        rom = '{32'h7F800000, 32'h00000000, 32'h3F800000, 32'h3F800000,
                32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        do_start(1'b0);
        repeat (7) @(negedge clk);
        check("exc_before_wr", 32'(exc_flags), 32'd0);
        @(negedge clk);
        check("exc_after_wr", 32'(exc_flags), 32'd4);
        wait_run(-5, -1, n, s0, s1, bok);
        check("exc_run_done", 32'(done), 32'd1);
        check("exc_sticky", 32'(exc_flags), 32'd4);
        do_start(1'b0);
        check("exc_cleared", 32'(exc_flags), 32'd0);
        wait_run(-5, -1, n, s0, s1, bok);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
